// File: rtl/l1_wishbone_burst_arbiter.sv
// l1_wishbone_burst_arbiter
// Round-robin arbiter that funnels NUM_PORTS L1 request channels onto a single
// Wishbone B4 master. Reads become incrementing bursts, writes are single beats.
// Bus errors and watchdog expiry are returned to the owning port as rsp_err.
//
// Handshake: a port raises req_request with its request fields stable and holds
// them until req_ack pulses for exactly one cycle; the port may drop or change
// the request from the cycle after that pulse. Requests are only sampled while
// the FSM is IDLE. On the bus, wb_stb always equals wb_cyc and a beat completes
// on any rising edge that sees wb_ack or wb_err high while wb_stb is high.
module l1_wishbone_burst_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req_request,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_rnw,
  input  logic [NUM_PORTS*4-1:0] req_be,
  input  logic [NUM_PORTS*5-1:0] req_size,
  output logic [NUM_PORTS-1:0]   req_ack,
  output logic [31:0]            rsp_data,
  output logic [NUM_PORTS-1:0]   rsp_data_valid,
  output logic [NUM_PORTS-1:0]   rsp_err,
  output logic [29:0]            wb_adr,
  output logic [31:0]            wb_dat_w,
  output logic [3:0]             wb_sel,
  output logic                   wb_we,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic [2:0]             wb_cti,
  output logic [1:0]             wb_bte,
  input  logic [31:0]            wb_dat_r,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  output logic [1:0]             dbg_state
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [4:0]      MAX_LAST = 5'(MAX_BURST - 1);
  localparam logic [WD_W-1:0] WD_LAST  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic [PW-1:0]          port_q, port_d;
  logic [4:0]             last_q, last_d;
  logic [4:0]             beat_q, beat_d;
  logic [29:0]            adr_q, adr_d;
  logic [31:0]            dat_w_q, dat_w_d;
  logic [3:0]             sel_q, sel_d;
  logic                   we_q, we_d;
  logic                   cyc_q, cyc_d;
  logic [2:0]             cti_q, cti_d;
  logic [NUM_PORTS-1:0]   req_ack_q, req_ack_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS-1:0]   rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                   found;
  logic [PW-1:0]          win;
  int                     idx;
  logic [4:0]             sz;
  logic                   timeout;

  // Round-robin search: first requesting port at or after the rr pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_q) + i) % NUM_PORTS;
      if (!found && req_request[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state and next-output computation for the transfer FSM and watchdog.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    port_d      = port_q;
    last_d      = last_q;
    beat_d      = beat_q;
    adr_d       = adr_q;
    dat_w_d     = dat_w_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    cti_d       = cti_q;
    rsp_data_d  = rsp_data_q;
    req_ack_d   = '0;
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    sz          = req_size[5*int'(win) +: 5];

    // Stalled strobe cycles; any termination or idle bus clears it.
    timeout = (TIMEOUT_CYCLES != 0) && cyc_q && !wb_ack && !wb_err && (wd_q == WD_LAST);
    if (cyc_q && !wb_ack && !wb_err) wd_d = wd_q + 1'b1;
    else                             wd_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          port_d         = win;
          rr_d           = (int'(win) == NUM_PORTS - 1) ? '0 : PW'(int'(win) + 1);
          req_ack_d[win] = 1'b1;
          cyc_d          = 1'b1;
          beat_d         = '0;
          adr_d          = req_addr[32*int'(win) + 2 +: 30];
          dat_w_d        = req_data[32*int'(win) +: 32];
          if (req_rnw[win]) begin
            state_d = ST_READ;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            last_d  = (sz > MAX_LAST) ? MAX_LAST : sz;
            cti_d   = (last_d == 5'd0) ? 3'b000 : 3'b010;
          end else begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            sel_d   = req_be[4*int'(win) +: 4];
            last_d  = '0;
            cti_d   = 3'b000;
          end
        end
      end
      ST_READ: begin
        if (wb_err || timeout) begin
          rsp_err_d[port_q] = 1'b1;
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (wb_ack) begin
          rsp_data_d          = wb_dat_r;
          rsp_valid_d[port_q] = 1'b1;
          if (beat_q == last_q) begin
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 5'd1;
            adr_d  = adr_q + 30'd1;
            cti_d  = (beat_q + 5'd1 == last_q) ? 3'b111 : 3'b010;
          end
        end
      end
      ST_WRITE: begin
        if (wb_err || timeout) begin
          rsp_err_d[port_q] = 1'b1;
          cyc_d   = 1'b0;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (wb_ack) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      port_q      <= '0;
      last_q      <= '0;
      beat_q      <= '0;
      adr_q       <= '0;
      dat_w_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      cti_q       <= '0;
      req_ack_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      adr_q       <= adr_d;
      dat_w_q     <= dat_w_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      cti_q       <= cti_d;
      req_ack_q   <= req_ack_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      wd_q        <= wd_d;
    end
  end

  assign req_ack        = req_ack_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_data_valid = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign wb_adr         = adr_q;
  assign wb_dat_w       = dat_w_q;
  assign wb_sel         = sel_q;
  assign wb_we          = we_q;
  assign wb_cyc         = cyc_q;
  assign wb_stb         = cyc_q;
  assign wb_cti         = cti_q;
  assign wb_bte         = 2'b00;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_l1_wishbone_burst_arbiter.sv
// Bench for l1_wishbone_burst_arbiter: directed scenarios plus randomized
// single-port traffic against a transaction-level model of the arbiter.
module tb_l1_wishbone_burst_arbiter;

  localparam int N  = 2;
  localparam int MB = 16;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_request;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_rnw;
  logic [N*4-1:0]  req_be;
  logic [N*5-1:0]  req_size;
  logic [N-1:0]    req_ack;
  logic [31:0]     rsp_data;
  logic [N-1:0]    rsp_data_valid;
  logic [N-1:0]    rsp_err;
  logic [29:0]     wb_adr;
  logic [31:0]     wb_dat_w;
  logic [3:0]      wb_sel;
  logic            wb_we, wb_cyc, wb_stb;
  logic [2:0]      wb_cti;
  logic [1:0]      wb_bte;
  logic [31:0]     wb_dat_r;
  logic            wb_ack, wb_err;
  logic [1:0]      dbg_state;

  l1_wishbone_burst_arbiter #(.NUM_PORTS(N), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_request(req_request), .req_addr(req_addr), .req_data(req_data),
    .req_rnw(req_rnw), .req_be(req_be), .req_size(req_size), .req_ack(req_ack),
    .rsp_data(rsp_data), .rsp_data_valid(rsp_data_valid), .rsp_err(rsp_err),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int rr_model = 0;
  logic [31:0] exp_q[$];

  // ---------------- Wishbone slave model ----------------
  int max_wait     = 0;
  int err_beat     = -1;
  bit slave_silent = 1'b0;
  int wait_cnt     = 0;
  int beat_idx     = 0;
  logic slave_go;

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    return {a[15:0] ^ 16'hC35A, 2'b10, a[13:0]};
  endfunction

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!wb_stb) begin
      beat_idx <= 0;
      wait_cnt <= (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
    end else if (wb_ack || wb_err) begin
      beat_idx <= beat_idx + 1;
      wait_cnt <= (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
    end else if (wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  assign slave_go = wb_stb && !slave_silent && (wait_cnt == 0);
  assign wb_ack   = slave_go && (beat_idx != err_beat);
  assign wb_err   = slave_go && (beat_idx == err_beat);
  assign wb_dat_r = mem_fn(wb_adr);

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input bit rnw, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input logic [4:0] size);
    req_rnw[p]          = rnw;
    req_addr[32*p +: 32] = addr;
    req_data[32*p +: 32] = data;
    req_be[4*p +: 4]     = be;
    req_size[5*p +: 5]   = size;
    req_request[p]       = 1'b1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300 && wb_cyc; c++) @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b0) $display("FAIL idle_wait: wb_cyc=%b required 0 within budget", wb_cyc);
    else n_pass++;
  endtask

  // Single read from one port; model derives beats, addresses, cti and data.
  task automatic run_read(input int p, input logic [31:0] addr, input logic [4:0] size, input int eb);
    int beats, k, nval, nerr, exp_val, exp_err;
    bit done;
    logic [29:0] a;
    logic [31:0] e;
    logic [2:0]  cti_e;
    beats   = ((int'(size) > MB - 1) ? MB - 1 : int'(size)) + 1;
    exp_err = (eb >= 0 && eb < beats) ? 1 : 0;
    exp_val = exp_err ? eb : beats;
    err_beat = eb;
    exp_q.delete();
    @(negedge clk);
    drive_req(p, 1'b1, addr, $urandom, 4'h0, size);
    @(negedge clk);
    n_checks++;
    if (req_ack !== oh(p)) $display("FAIL rd_req_ack: got %b required %b", req_ack, oh(p));
    else n_pass++;
    req_request[p] = 1'b0;
    rr_model = (p + 1) % N;
    k = 0; nval = 0; nerr = 0; done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rsp_data_valid !== '0) begin
        nval++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (rsp_data_valid !== oh(p) || rsp_data !== e)
          $display("FAIL rd_rsp: valid=%b data=%h required valid=%b data=%h", rsp_data_valid, rsp_data, oh(p), e);
        else n_pass++;
      end
      if (rsp_err !== '0) begin
        nerr++;
        n_checks++;
        if (rsp_err !== oh(p)) $display("FAIL rd_err_port: got %b required %b", rsp_err, oh(p));
        else n_pass++;
      end
      if (done) begin
        n_checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) $display("FAIL rd_cyc_drop: cyc=%b stb=%b required 0", wb_cyc, wb_stb);
        else n_pass++;
        break;
      end
      if (wb_stb && (wb_ack || wb_err)) begin
        a     = addr[31:2] + 30'(k);
        cti_e = (beats == 1) ? 3'b000 : ((k == beats - 1) ? 3'b111 : 3'b010);
        n_checks++;
        if (wb_adr !== a || wb_cti !== cti_e || wb_we !== 1'b0 || wb_sel !== 4'hF || wb_bte !== 2'b00)
          $display("FAIL rd_beat%0d: adr=%h cti=%b we=%b sel=%h required adr=%h cti=%b we=0 sel=f",
                   k, wb_adr, wb_cti, wb_we, wb_sel, a, cti_e);
        else n_pass++;
        if (!wb_err) exp_q.push_back(mem_fn(a));
        k++;
        if (wb_err || k == beats) done = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (nval != exp_val || nerr != exp_err || !done)
      $display("FAIL rd_summary: valid_pulses=%0d err_pulses=%0d done=%0d required %0d %0d 1", nval, nerr, done, exp_val, exp_err);
    else n_pass++;
    err_beat = -1;
  endtask

  task automatic run_write(input int p, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int nbeat, nval;
    bit done;
    @(negedge clk);
    drive_req(p, 1'b0, addr, data, be, 5'($urandom_range(0, 31)));
    @(negedge clk);
    n_checks++;
    if (req_ack !== oh(p)) $display("FAIL wr_req_ack: got %b required %b", req_ack, oh(p));
    else n_pass++;
    req_request[p] = 1'b0;
    rr_model = (p + 1) % N;
    nbeat = 0; nval = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_data_valid !== '0 || rsp_err !== '0) nval++;
      if (done) break;
      if (wb_stb && wb_ack) begin
        nbeat++;
        n_checks++;
        if (wb_adr !== addr[31:2] || wb_sel !== be || wb_we !== 1'b1 || wb_dat_w !== data || wb_cti !== 3'b000)
          $display("FAIL wr_beat: adr=%h sel=%b we=%b dat=%h cti=%b required adr=%h sel=%b we=1 dat=%h cti=000",
                   wb_adr, wb_sel, wb_we, wb_dat_w, wb_cti, addr[31:2], be, data);
        else n_pass++;
        done = 1'b1;
      end
      @(negedge clk);
    end
    repeat (2) begin
      if (rsp_data_valid !== '0 || rsp_err !== '0) nval++;
      @(negedge clk);
    end
    n_checks++;
    if (nbeat != 1 || nval != 0 || wb_cyc !== 1'b0)
      $display("FAIL wr_summary: beats=%0d responses=%0d cyc=%b required 1 0 0", nbeat, nval, wb_cyc);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, req_ack, rsp_data_valid, rsp_err} !== '0 || wb_adr !== '0 ||
        rsp_data !== '0 || wb_cti !== '0 || wb_sel !== '0 || wb_dat_w !== '0 || dbg_state !== 2'd0)
      $display("FAIL reset_outputs: cyc=%b ack=%b valid=%b adr=%h state=%0d required all zero",
               wb_cyc, req_ack, rsp_data_valid, wb_adr, dbg_state);
    else n_pass++;
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_burst_read();
    max_wait = 0;
    run_read(0, 32'h0000_1000, 5'd3, -1);
  endtask

  task automatic test_write();
    max_wait = 0;
    run_write(1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011);
  endtask

  task automatic test_error();
    max_wait = 0;
    run_read(0, 32'h0000_3000, 5'd3, 1);
  endtask

  task automatic test_timeout();
    int nstb;
    max_wait = 0;
    slave_silent = 1'b1;
    @(negedge clk);
    drive_req(0, 1'b1, 32'h0000_4000, 32'h0, 4'h0, 5'd3);
    @(negedge clk);
    req_request[0] = 1'b0;
    rr_model = 1;
    nstb = 0;
    for (int c = 0; c < 50 && wb_stb; c++) begin
      nstb++;
      @(negedge clk);
    end
    n_checks++;
    if (nstb != TO || rsp_err !== oh(0) || rsp_data_valid !== '0)
      $display("FAIL timeout_abort: stb_cycles=%0d rsp_err=%b valid=%b required %0d %b 00",
               nstb, rsp_err, rsp_data_valid, TO, oh(0));
    else n_pass++;
    slave_silent = 1'b0;
  endtask

  task automatic test_wrap_clip();
    max_wait = 1;
    run_read(0, 32'hFFFF_FFF8, 5'd31, -1);
  endtask

  // Both ports keep requesting; grants must follow the rotating pointer.
  task automatic test_round_robin();
    int grants, w;
    logic [N-1:0] prev;
    max_wait = 2;
    @(negedge clk);
    for (int p = 0; p < N; p++) drive_req(p, 1'b1, $urandom, 32'h0, 4'h0, 5'($urandom_range(0, 2)));
    grants = 0; prev = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (req_ack !== '0) begin
        w = rr_model;
        n_checks++;
        if (req_ack !== oh(w) || prev !== '0)
          $display("FAIL rr_grant%0d: ack=%b prev=%b required %b after 00", grants, req_ack, prev, oh(w));
        else n_pass++;
        rr_model = (w + 1) % N;
        grants++;
      end
      prev = req_ack;
    end
    req_request = '0;
    wait_idle();
    n_checks++;
    if (grants < 4) $display("FAIL rr_count: grants=%0d required at least 4", grants);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    max_wait = 0;
    @(negedge clk);
    drive_req(0, 1'b1, 32'h0000_5000, 32'h0, 4'h0, 5'd15);
    @(negedge clk);
    req_request[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, req_ack, rsp_data_valid, rsp_err} !== '0)
      $display("FAIL reset_mid: cyc=%b stb=%b ack=%b valid=%b required all zero", wb_cyc, wb_stb, req_ack, rsp_data_valid);
    else n_pass++;
    rr_model = 0;
    for (int p = 0; p < N; p++) drive_req(p, 1'b1, $urandom, 32'h0, 4'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== oh(0)) $display("FAIL reset_first_grant: got %b required %b", req_ack, oh(0));
    else n_pass++;
    req_request = '0;
    rr_model = 1;
    wait_idle();
  endtask

  task automatic test_random();
    int p, eb;
    for (int t = 0; t < 24; t++) begin
      p = int'($urandom_range(0, N - 1));
      max_wait = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        run_write(p, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
        run_read(p, $urandom, 5'($urandom_range(0, 31)), eb);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    req_request = '0; req_addr = '0; req_data = '0;
    req_rnw = '0; req_be = '0; req_size = '0;
    test_reset();
    test_burst_read();
    test_write();
    test_error();
    test_timeout();
    test_wrap_clip();
    test_round_robin();
    test_reset_mid_burst();
    test_random();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
